// File: rtl/alu_8bit.sv
// 8-bit registered ALU: 20 base operations with status flags and a one-cycle result_ready
// pulse that qualifies each accepted operation.
// Optional build macro ALU_MUL_EN: when defined, opcode 20 is a signed multiply (low
// WIDTH bits of the product). Otherwise opcode 20 is invalid like 21-31.
module alu_8bit #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] operand_A,
  input  logic [WIDTH-1:0] operand_B,
  input  logic             enable,
  input  logic             input_ready,
  input  logic             carry_in,
  input  logic             borrow_in,
  output logic [WIDTH-1:0] result_out,
  output logic             result_ready,
  output logic             carry_out,
  output logic             borrow_out,
  output logic             zero,
  output logic             negative,
  output logic             overflow
);

  localparam int unsigned Msb = WIDTH - 1;

  typedef enum logic [4:0] {
    OpAdd  = 5'd0,
    OpAdc  = 5'd1,
    OpSub  = 5'd2,
    OpSbb  = 5'd3,
    OpInc  = 5'd4,
    OpDec  = 5'd5,
    OpAnd  = 5'd6,
    OpOr   = 5'd7,
    OpXor  = 5'd8,
    OpNand = 5'd9,
    OpNor  = 5'd10,
    OpXnor = 5'd11,
    OpNot  = 5'd12,
    OpShl  = 5'd13,
    OpShr  = 5'd14,
    OpSar  = 5'd15,
    OpRol  = 5'd16,
    OpRor  = 5'd17,
    OpNeg  = 5'd18,
    OpCmp  = 5'd19,
    OpMul  = 5'd20
  } op_e;

  op_e op;
  assign op = op_e'(opcode);

  // Shared adder/subtractor operands
  logic [WIDTH-1:0] arith_a;
  logic [WIDTH-1:0] arith_b;
  logic             arith_cin;
  logic             arith_is_sub;
  logic             arith_sel;

  // Shared adder/subtractor results
  logic [WIDTH:0]   arith_sum;
  logic [WIDTH-1:0] arith_res;
  logic             arith_carry;
  logic             arith_borrow;
  logic             arith_ovf;

  // Logic unit and shifter results
  logic [WIDTH-1:0] logic_res;
  logic             logic_sel;
  logic [WIDTH-1:0] shift_res;
  logic             shift_cout;
  logic             shift_sel;

  // Multiplier results (tied off when the feature is disabled)
  logic [WIDTH-1:0] mul_res;
  logic             mul_ovf;
  logic             mul_sel;

  // Selected next-state values
  logic             accept;
  logic             write_result;
  logic [WIDTH-1:0] value_d;
  logic             carry_d;
  logic             borrow_d;
  logic             ovf_d;

  // Registered state
  logic [WIDTH-1:0] result_q;
  logic             ready_q;
  logic             carry_q;
  logic             borrow_q;
  logic             zero_q;
  logic             negative_q;
  logic             ovf_q;

  // Operand steering for the shared adder; subtraction is A + ~B + ~borrow
  always_comb begin
    arith_a      = operand_A;
    arith_b      = operand_B;
    arith_cin    = 1'b0;
    arith_is_sub = 1'b0;
    arith_sel    = 1'b1;
    unique case (op)
      OpAdd: ;
      OpAdc: arith_cin = carry_in;
      OpInc: arith_b = WIDTH'(1);
      OpSub, OpCmp: arith_is_sub = 1'b1;
      OpSbb: begin
        arith_is_sub = 1'b1;
        arith_cin    = borrow_in;
      end
      OpDec: begin
        arith_is_sub = 1'b1;
        arith_b      = WIDTH'(1);
      end
      OpNeg: begin
        arith_is_sub = 1'b1;
        arith_a      = '0;
        arith_b      = operand_A;
      end
      default: arith_sel = 1'b0;
    endcase
  end

  // Adder core with unsigned carry/borrow and signed overflow
  always_comb begin
    if (arith_is_sub) begin
      arith_sum = {1'b0, arith_a} + {1'b0, ~arith_b} + {{WIDTH{1'b0}}, ~arith_cin};
    end else begin
      arith_sum = {1'b0, arith_a} + {1'b0, arith_b} + {{WIDTH{1'b0}}, arith_cin};
    end
    arith_res = arith_sum[Msb:0];
    if (arith_is_sub) begin
      // No carry out of A + ~B + ~bin means the true difference went negative
      arith_carry  = 1'b0;
      arith_borrow = ~arith_sum[WIDTH];
      arith_ovf    = (arith_a[Msb] != arith_b[Msb]) && (arith_res[Msb] != arith_a[Msb]);
    end else begin
      arith_carry  = arith_sum[WIDTH];
      arith_borrow = 1'b0;
      arith_ovf    = (arith_a[Msb] == arith_b[Msb]) && (arith_res[Msb] != arith_a[Msb]);
    end
  end

  // Bitwise logic unit
  always_comb begin
    logic_res = '0;
    logic_sel = 1'b1;
    unique case (op)
      OpAnd:   logic_res = operand_A & operand_B;
      OpOr:    logic_res = operand_A | operand_B;
      OpXor:   logic_res = operand_A ^ operand_B;
      OpNand:  logic_res = ~(operand_A & operand_B);
      OpNor:   logic_res = ~(operand_A | operand_B);
      OpXnor:  logic_res = ~(operand_A ^ operand_B);
      OpNot:   logic_res = ~operand_A;
      default: logic_sel = 1'b0;
    endcase
  end

  // Single-bit shifter/rotator; carry reports the bit shifted out
  always_comb begin
    shift_res  = '0;
    shift_cout = 1'b0;
    shift_sel  = 1'b1;
    unique case (op)
      OpShl: begin
        shift_res  = {operand_A[Msb-1:0], 1'b0};
        shift_cout = operand_A[Msb];
      end
      OpShr: begin
        shift_res  = {1'b0, operand_A[Msb:1]};
        shift_cout = operand_A[0];
      end
      OpSar: begin
        shift_res  = {operand_A[Msb], operand_A[Msb:1]};
        shift_cout = operand_A[0];
      end
      OpRol: begin
        shift_res  = {operand_A[Msb-1:0], operand_A[Msb]};
        shift_cout = operand_A[Msb];
      end
      OpRor: begin
        shift_res  = {operand_A[0], operand_A[Msb:1]};
        shift_cout = operand_A[0];
      end
      default: shift_sel = 1'b0;
    endcase
  end

`ifdef ALU_MUL_EN
  logic signed [2*WIDTH-1:0] product;

  // Signed multiply; overflow when the upper half is not a sign extension of the low half
  always_comb begin
    product = $signed(operand_A) * $signed(operand_B);
    mul_res = product[Msb:0];
    mul_ovf = !((&product[2*WIDTH-1:Msb]) || !(|product[2*WIDTH-1:Msb]));
    mul_sel = (op == OpMul);
  end
`else
  // Multiply disabled: opcode 20 decodes as invalid
  always_comb begin
    mul_res = '0;
    mul_ovf = 1'b0;
    mul_sel = 1'b0;
  end
`endif

  // Result/flag selection and acceptance
  always_comb begin
    value_d      = '0;
    carry_d      = 1'b0;
    borrow_d     = 1'b0;
    ovf_d        = 1'b0;
    write_result = 1'b1;
    if (arith_sel) begin
      value_d  = arith_res;
      carry_d  = arith_carry;
      borrow_d = arith_borrow;
      ovf_d    = arith_ovf;
      // CMP updates flags only
      write_result = (op != OpCmp);
    end else if (logic_sel) begin
      value_d = logic_res;
    end else if (shift_sel) begin
      value_d = shift_res;
      carry_d = shift_cout;
    end else if (mul_sel) begin
      value_d = mul_res;
      ovf_d   = mul_ovf;
    end
    accept = enable && input_ready && (arith_sel || logic_sel || shift_sel || mul_sel);
  end

  // Output registers: cleared by reset, updated only on an accepted operation
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q   <= '0;
      ready_q    <= 1'b0;
      carry_q    <= 1'b0;
      borrow_q   <= 1'b0;
      zero_q     <= 1'b0;
      negative_q <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      ready_q <= accept;
      if (accept) begin
        if (write_result) begin
          result_q <= value_d;
        end
        carry_q    <= carry_d;
        borrow_q   <= borrow_d;
        zero_q     <= (value_d == '0);
        negative_q <= value_d[Msb];
        ovf_q      <= ovf_d;
      end
    end
  end

  assign result_out   = result_q;
  assign result_ready = ready_q;
  assign carry_out    = carry_q;
  assign borrow_out   = borrow_q;
  assign zero         = zero_q;
  assign negative     = negative_q;
  assign overflow     = ovf_q;

endmodule

// File: tb/tb_alu_8bit.sv
// Randomized self-checking bench for alu_8bit against an integer-arithmetic reference model,
// preceded by a short directed sequence of known cases.
module tb_alu_8bit;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] opcode;
  logic [7:0] operand_A;
  logic [7:0] operand_B;
  logic       enable;
  logic       input_ready;
  logic       carry_in;
  logic       borrow_in;
  logic [7:0] result_out;
  logic       result_ready;
  logic       carry_out;
  logic       borrow_out;
  logic       zero;
  logic       negative;
  logic       overflow;

  always #5 clk = ~clk;

  alu_8bit dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .operand_A    (operand_A),
    .operand_B    (operand_B),
    .enable       (enable),
    .input_ready  (input_ready),
    .carry_in     (carry_in),
    .borrow_in    (borrow_in),
    .result_out   (result_out),
    .result_ready (result_ready),
    .carry_out    (carry_out),
    .borrow_out   (borrow_out),
    .zero         (zero),
    .negative     (negative),
    .overflow     (overflow)
  );

  int checks = 0;
  int errors = 0;

  // Expected output state
  logic [7:0] m_res = '0;
  logic       m_rdy = 1'b0;
  logic       m_c   = 1'b0;
  logic       m_b   = 1'b0;
  logic       m_z   = 1'b0;
  logic       m_n   = 1'b0;
  logic       m_v   = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (op %0d A %0h B %0h)", tag, got, exp, opcode,
               operand_A, operand_B);
    end
  endtask

  function automatic bit out_of_range(input int v);
    return (v > 127) || (v < -128);
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    int a, b, sa, sb, r, p;
    bit valid, wr;
    logic [7:0] r8;
    if (rst) begin
      m_res = '0; m_rdy = 0; m_c = 0; m_b = 0; m_z = 0; m_n = 0; m_v = 0;
      return;
    end
`ifdef ALU_MUL_EN
    valid = (opcode <= 20);
`else
    valid = (opcode <= 19);
`endif
    m_rdy = enable && input_ready && valid;
    if (!m_rdy) return;
    a  = int'(operand_A);
    b  = int'(operand_B);
    sa = int'($signed(operand_A));
    sb = int'($signed(operand_B));
    wr = 1;
    r  = 0;
    m_c = 0; m_b = 0; m_v = 0;
    case (opcode)
      0:  begin r = a + b;            m_c = r > 255; m_v = out_of_range(sa + sb); end
      1:  begin r = a + b + carry_in; m_c = r > 255; m_v = out_of_range(sa + sb + carry_in); end
      4:  begin r = a + 1;            m_c = r > 255; m_v = out_of_range(sa + 1); end
      2:  begin r = a - b;             m_b = r < 0; m_v = out_of_range(sa - sb); end
      3:  begin r = a - b - borrow_in; m_b = r < 0; m_v = out_of_range(sa - sb - borrow_in); end
      5:  begin r = a - 1;             m_b = r < 0; m_v = out_of_range(sa - 1); end
      18: begin r = 0 - a;             m_b = r < 0; m_v = out_of_range(0 - sa); end
      19: begin r = a - b;             m_b = r < 0; m_v = out_of_range(sa - sb); wr = 0; end
      6:  r = a & b;
      7:  r = a | b;
      8:  r = a ^ b;
      9:  r = 255 - (a & b);
      10: r = 255 - (a | b);
      11: r = 255 - (a ^ b);
      12: r = 255 - a;
      13: begin r = a * 2;                      m_c = a >= 128; end
      14: begin r = a / 2;                      m_c = a % 2; end
      15: begin r = a / 2 + (a >= 128 ? 128 : 0); m_c = a % 2; end
      16: begin r = (a * 2) % 256 + a / 128;    m_c = a >= 128; end
      17: begin r = a / 2 + (a % 2) * 128;      m_c = a % 2; end
`ifdef ALU_MUL_EN
      20: begin p = sa * sb; r = p; m_v = out_of_range(p); end
`endif
      default: r = 0;
    endcase
    r8 = r[7:0];
    if (wr) m_res = r8;
    m_z = (r8 == 8'h00);
    m_n = r8[7];
  endtask

  task automatic compare_all();
    check_eq("result_out", result_out, m_res);
    check_eq("result_ready", result_ready, m_rdy);
    check_eq("carry_out", carry_out, m_c);
    check_eq("borrow_out", borrow_out, m_b);
    check_eq("zero", zero, m_z);
    check_eq("negative", negative, m_n);
    check_eq("overflow", overflow, m_v);
  endtask

  // Apply one cycle of stimulus, clock it, and compare against the model
  task automatic drive(input logic r, input logic [4:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic ci, input logic bi,
                       input logic en, input logic ir);
    rst = r; opcode = op; operand_A = a; operand_B = b;
    carry_in = ci; borrow_in = bi; enable = en; input_ready = ir;
    model_edge();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  function automatic logic [7:0] pick_operand();
    logic [7:0] corners [5] = '{8'h00, 8'h01, 8'h7F, 8'h80, 8'hFF};
    if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
    return 8'($urandom);
  endfunction

  initial begin
    logic [4:0] op;
    rst = 1; opcode = 0; operand_A = 0; operand_B = 0;
    carry_in = 0; borrow_in = 0; enable = 1; input_ready = 1;

    // Reset with a valid operation presented
    drive(1, 5'd0, 8'h12, 8'h34, 0, 0, 1, 1);
    check_eq("plan_reset_result", result_out, 8'h00);
    check_eq("plan_reset_ready", result_ready, 1'b0);

    drive(0, 5'd0, 8'd127, 8'd126, 0, 0, 1, 1);
    check_eq("plan_add_result", result_out, 8'hFD);
    check_eq("plan_add_ovf", overflow, 1'b1);
    drive(0, 5'd1, 8'd127, 8'd126, 1, 0, 1, 1);
    check_eq("plan_adc_result", result_out, 8'hFE);
    drive(0, 5'd1, 8'hFF, 8'h01, 0, 0, 1, 1);
    check_eq("plan_adc_carry", carry_out, 1'b1);
    drive(0, 5'd3, 8'd5, 8'd7, 0, 1, 1, 1);
    check_eq("plan_sbb_result", result_out, 8'hFD);
    drive(0, 5'd19, 8'd9, 8'd9, 0, 0, 1, 1);
    check_eq("plan_cmp_zero", zero, 1'b1);
    check_eq("plan_cmp_hold", result_out, 8'hFD);
    drive(0, 5'd6, 8'hF0, 8'h0F, 0, 0, 1, 1);
    drive(0, 5'd16, 8'h81, 8'h00, 0, 0, 1, 1);
    check_eq("plan_rol_result", result_out, 8'h03);
    drive(0, 5'd15, 8'h80, 8'h00, 0, 0, 1, 1);
    check_eq("plan_sar_result", result_out, 8'hC0);
    drive(0, 5'd0, 8'h11, 8'h22, 0, 0, 1, 0);
    drive(0, 5'd0, 8'h11, 8'h22, 0, 0, 0, 1);
    drive(0, 5'd25, 8'h11, 8'h22, 0, 0, 1, 1);
    check_eq("plan_invalid_hold", result_out, 8'hC0);
    drive(0, 5'd20, 8'h03, 8'h05, 0, 0, 1, 1);
    drive(0, 5'd0, 8'h40, 8'h01, 0, 0, 1, 1);
    check_eq("plan_pre_rst_ready", result_ready, 1'b1);
    drive(1, 5'd0, 8'h40, 8'h01, 0, 0, 1, 1);
    check_eq("plan_rst_result", result_out, 8'h00);
    // Back-to-back corners for inc/dec/neg
    drive(0, 5'd4, 8'h7F, 8'h00, 1, 1, 1, 1);
    drive(0, 5'd5, 8'h80, 8'h00, 1, 1, 1, 1);
    drive(0, 5'd5, 8'h00, 8'h00, 1, 1, 1, 1);
    drive(0, 5'd18, 8'h80, 8'h00, 1, 1, 1, 1);
    drive(0, 5'd18, 8'h00, 8'h00, 1, 1, 1, 1);

    for (int i = 0; i < 3000; i++) begin
      op = ($urandom_range(0, 3) != 0) ? 5'($urandom_range(0, 20)) : 5'($urandom_range(0, 31));
      drive($urandom_range(0, 49) == 0, op, pick_operand(), pick_operand(),
            1'($urandom), 1'($urandom), $urandom_range(0, 9) != 0, $urandom_range(0, 7) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_8bit.md
Name: alu_8bit

Overview:
- 8-bit registered ALU with 5-bit opcode, 20 base operations (arithmetic, logic, shift/rotate, compare) and status flags.
- Sits between the register file and the operand bus of the datapath.
- Result and flags are registered one cycle after an accepted operation.
- result_ready pulses to qualify each new result.

Parameters:
- WIDTH, 8, operand/result width; all behaviour below is specified for 8.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- opcode  in  5  operation select.
- operand_A  in  8  first operand, two's complement.
- operand_B  in  8  second operand, two's complement.
- enable  in  1  block enable.
- input_ready  in  1  operands/opcode valid this cycle.
- carry_in  in  1  carry for ADC.
- borrow_in  in  1  borrow for SBB.
- result_out  out  8  registered result.
- result_ready  out  1  one-cycle pulse: result_out and flags updated.
- carry_out  out  1  unsigned carry / shifted-out bit.
- borrow_out  out  1  unsigned borrow (A < B with borrow).
- zero  out  1  result_out == 0.
- negative  out  1  result_out[7].
- overflow  out  1  signed overflow.

Behaviour:
- rst=1 at a clock edge: all outputs cleared to 0; overrides enable and any operation in progress.
- Operation accepted at an edge when enable=1 and input_ready=1 and opcode valid.
  - Next cycle: result_out and all flags hold the new values; result_ready=1 for exactly that cycle.
  - Latency is 1 cycle; back-to-back operations are accepted every cycle.
- Not accepted (enable=0, or input_ready=0, or invalid opcode):
  - result_out and flags hold their previous values.
  - result_ready=0.
- Opcode map (A=operand_A, B=operand_B, results truncated to 8 bits):
  - 0 ADD: A+B.
  - 1 ADC: A+B+carry_in.
  - 2 SUB: A-B.
  - 3 SBB: A-B-borrow_in.
  - 4 INC: A+1.
  - 5 DEC: A-1.
  - 6 AND, 7 OR, 8 XOR, 9 NAND, 10 NOR, 11 XNOR: bitwise A op B.
  - 12 NOT: ~A.
  - 13 SHL: A<<1; carry_out=A[7].
  - 14 SHR: logical A>>1; carry_out=A[0].
  - 15 SAR: arithmetic A>>>1; carry_out=A[0].
  - 16 ROL: {A[6:0],A[7]}; carry_out=A[7].
  - 17 ROR: {A[0],A[7:1]}; carry_out=A[0].
  - 18 NEG: 0-A; overflow=1 only when A=-128.
  - 19 CMP: computes A-B; only flags update; result_out holds; result_ready still pulses.
  - 20-31: invalid (except as under Optional Feature).
- Flag rules:
  - ADD/ADC/INC: carry_out = bit 8 of the unsigned 9-bit sum; borrow_out=0.
  - SUB/SBB/DEC/NEG/CMP: borrow_out = unsigned borrow; carry_out=0.
  - overflow (signed):
    - add ops: operands of equal sign and result sign differs.
    - sub ops: operand signs differ and result sign differs from A.
  - Logic ops, NOT: carry_out, borrow_out, overflow = 0.
  - Shift/rotate ops: borrow_out=0, overflow=0.
  - zero and negative always reflect the value written to result_out; for CMP they reflect the computed difference A-B.
- carry_in is ignored except by ADC; borrow_in is ignored except by SBB.

Optional Feature:
- Macro ALU_MUL_EN.
- Defined: opcode 20 = MUL, signed A*B.
  - result_out = low 8 bits of the product.
  - overflow=1 when the product lies outside -128..127.
  - carry_out=0, borrow_out=0.
  - Same 1-cycle latency.
- Undefined: opcode 20 is invalid (no update, result_ready=0).

Test Plan:
- rst=1 for one edge with enable=1, input_ready=1 -> all outputs 0 next cycle; result_ready=0.
- ADD A=127, B=126 -> result_out=0xFD (-3), carry_out=0, overflow=1, negative=1, zero=0; result_ready pulses one cycle later.
- ADC A=127, B=126, carry_in=1 -> result_out=0xFE, overflow=1, carry_out=0. ADC A=0xFF, B=0x01, carry_in=0 -> result_out=0x00, carry_out=1, zero=1.
- SBB A=5, B=7, borrow_in=1 -> result_out=0xFD, borrow_out=1, negative=1. Then CMP A=9, B=9 -> zero=1, result_out still 0xFD.
- Logic and rotate:
  - AND A=0xF0, B=0x0F -> result_out=0, zero=1.
  - ROL A=0x81 -> result_out=0x03, carry_out=1.
  - SAR A=0x80 -> result_out=0xC0, carry_out=0.
- Handshake and reset:
  - input_ready=0 or enable=0 -> outputs hold, result_ready=0.
  - opcode=25 -> outputs hold, result_ready=0.
  - rst asserted while result_ready=1 -> all outputs 0 next cycle.
